bus_arbmux: RTL

- Parametrised registered bus multiplexer for the datapath. It drives the shared BusWires from one of NSRC sources: registers, ALU result G, and DIN.
- Two modes:
  - Direct mode: the control FSM supplies a one-hot select, as today.
  - Arbitrated mode: sources raise requests and a round-robin arbiter grants the bus, with bounded bus locking.
- Adds a registered output, a valid flag and sticky select-conflict detection.

---
 rtl/bus_arbmux_pkg.sv | 36 +++
 rtl/bus_arbmux_rr_arbiter.sv | 42 ++++
 rtl/bus_arbmux.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bus_arbmux_pkg.sv
// ============================================================================
// Module      : bus_arbmux_pkg
// Description : Shared encodings and helpers for the bus multiplexer/arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arbmux_pkg;

    localparam logic        MODE_DIRECT = 1'b0;
    localparam logic        MODE_ARB    = 1'b1;
    localparam int unsigned MAX_SRC     = 64;

    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_ONEHOT = 2'd1,
        SEL_MULTI  = 2'd2
    } sel_class_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // v & (v-1) clears the lowest set bit, so a zero result means at most one bit set.
    function automatic sel_class_e classify_sel(input logic [MAX_SRC-1:0] v);
        if (v == '0)
            return SEL_ZERO;
        else if ((v & (v - 1'b1)) == '0)
            return SEL_ONEHOT;
        else
            return SEL_MULTI;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbmux_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search starting at a given index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  winner_o,
    output logic [IW-1:0] winner_idx_o
);

    localparam logic [2*N-1:0] C_ONE = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_mask;
    logic [2*N-1:0] w_masked;
    logic [2*N-1:0] w_lowest;

    // Upper copy catches requests below start_i, giving the wrap-around.
    assign w_dbl    = {req_i, req_i};
    assign w_mask   = ~((C_ONE << start_i) - C_ONE);
    assign w_masked = w_dbl & w_mask;
    assign w_lowest = w_masked & (~w_masked + C_ONE);
    assign winner_o = w_lowest[N-1:0] | w_lowest[2*N-1:N];

    always_comb begin
        winner_idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (winner_o[i])
                winner_idx_o = IW'(i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbmux.sv
// ============================================================================
// Module      : bus_arbmux
// Description : Registered bus mux with direct one-hot select or round-robin
//               arbitration with bounded locking, plus sticky conflict flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbmux
    import bus_arbmux_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NSRC        = 10,
    parameter int DEFAULT_SRC = NSRC - 1,
    parameter int MAX_LOCK    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mode_i,
    input  logic [NSRC-1:0]       sel_i,
    input  logic [NSRC-1:0]       req_i,
    input  logic [NSRC-1:0]       lock_i,
    input  logic [WIDTH*NSRC-1:0] src_data_i,
    input  logic                  clear_err_i,
    output logic [WIDTH-1:0]      bus_wires_o,
    output logic                  bus_valid_o,
    output logic [NSRC-1:0]       grant_o,
    output logic                  conflict_o
);

    localparam int IW = int'(idx_width(NSRC));
    localparam int LW = int'(idx_width(MAX_LOCK));

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [NSRC-1:0]  grant_q, grant_d;
    logic             conflict_q, conflict_d;
    logic [IW-1:0]    last_q, last_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;

    logic [IW-1:0]    w_start;
    logic [NSRC-1:0]  w_arb_winner;
    logic [IW-1:0]    w_arb_idx;
    sel_class_e       w_sel_class;
    logic             w_lock_hold;
    logic [WIDTH-1:0] w_grant_data;

    assign w_start     = (last_q == IW'(NSRC - 1)) ? '0 : last_q + 1'b1;
    assign w_sel_class = classify_sel(MAX_SRC'(sel_i));
    assign w_lock_hold = (|(grant_q & req_i & lock_i)) && (lock_cnt_q < LW'(MAX_LOCK - 1));

    rr_arbiter #(
        .N  (NSRC),
        .IW (IW)
    ) u_arb (
        .req_i        (req_i),
        .start_i      (w_start),
        .winner_o     (w_arb_winner),
        .winner_idx_o (w_arb_idx)
    );

    // Lock counter is zeroed on every non-hold edge, which also covers mode changes.
    always_comb begin
        grant_d    = '0;
        last_d     = last_q;
        lock_cnt_d = '0;
        conflict_d = clear_err_i ? 1'b0 : conflict_q;
        if (mode_i == MODE_DIRECT) begin
            if (w_sel_class == SEL_ONEHOT)
                grant_d = sel_i;
            else if (w_sel_class == SEL_MULTI)
                conflict_d = 1'b1;
        end else if (w_lock_hold) begin
            grant_d    = grant_q;
            lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (|req_i) begin
            grant_d = w_arb_winner;
            last_d  = w_arb_idx;
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant_d[i])
                w_grant_data = w_grant_data | src_data_i[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        valid_d = |grant_d;
        bus_d   = bus_q;
        if (mode_i == MODE_DIRECT && w_sel_class == SEL_MULTI)
            bus_d = src_data_i[DEFAULT_SRC*WIDTH +: WIDTH];
        else if (valid_d)
            bus_d = w_grant_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_q      <= '0;
            valid_q    <= 1'b0;
            grant_q    <= '0;
            conflict_q <= 1'b0;
            last_q     <= IW'(NSRC - 1);
            lock_cnt_q <= '0;
        end else begin
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            grant_q    <= grant_d;
            conflict_q <= conflict_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign bus_wires_o = bus_q;
    assign bus_valid_o = valid_q;
    assign grant_o     = grant_q;
    assign conflict_o  = conflict_q;

endmodule

`default_nettype wire
